quantizer_pipe_x4: RTL and testbench
====================================

// Module: quantizer_pipe_x4
// PURPOSE
//  Four-lane pipelined FP32 -> integer quantizer; the inverse path of the dequantizer blocks.
//  Converts weights to signed levels: level = sat(RNE(w * 2^SCALE_EXP)), LEVEL_W bits, sign-extended to 32.
//  Sits between the FP weight datapath and level storage; valid/ready on both sides; counts saturation events.
// PARAMETERS
//  LEVEL_W    8   signed level width, legal 2..31
//  SCALE_EXP  0   signed power-of-two scale applied before rounding, legal -64..64
//  CNT_W      16  width of saturation event counter
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      reset, asynchronous, active-low
//  in_valid         in   1      input beat valid (all 4 lanes together)
//  in_ready         out  1      block accepts beat when in_valid & in_ready
//  weight_fp1..4    in   32     IEEE-754 single inputs, one per lane
//  is_weight1..4    in   1      1: quantize lane; 0: pass 32-bit word through unchanged
//  out_valid        out  1      output beat valid
//  out_ready        in   1      downstream accepts when out_valid & out_ready
//  level1..4        out  32     quantized level (sign-extended) or passthrough word
//  sat              out  4      per-lane saturation/invalid flag, aligned with level1..4 (bit0 = lane1)
//  clr_stats        in   1      synchronous clear of sat_count
//  sat_count        out  CNT_W  saturating count of flagged lanes in delivered beats
// BEHAVIOUR
//  - Reset (rst low, async): all stage valids 0, out_valid 0, level1..4 0, sat 0, sat_count 0.
//  - Pipeline: 3 stages, global enable en = ~out_valid | out_ready; in_ready = en (combinational).
//    S1 unpack/classify, E = exp-127+SCALE_EXP; S2 align 24-bit mantissa by E, keep guard+sticky;
//    S3 round, negate, saturate, register outputs. Latency 3 cycles with out_ready held high.
//  - Stall: when en=0 every stage holds; level/sat/out_valid stable until accepted; no drop, no duplicate, order kept.
//  - Bubbles propagate (no collapse); throughput 1 beat/cycle when unstalled.
//  - Lane arithmetic (is_weight=1), MAX=2^(LEVEL_W-1)-1, MIN=-2^(LEVEL_W-1):
//    zero or denormal (exp=0) -> 0, sat=0; -0 -> 0.
//    NaN -> 0, sat=1. +Inf -> MAX, sat=1. -Inf -> MIN, sat=1.
//    E <= -2 -> 0. Otherwise round-to-nearest-even on exact value, then apply sign.
//    Rounded magnitude > MAX (positive) -> MAX, sat=1; rounded result < MIN -> MIN, sat=1.
//    Result exactly MIN (incl. rounding up to 2^(LEVEL_W-1) when negative) -> MIN, sat=0.
//    Large E: shift clamps; any E >= LEVEL_W treated as overflow (no shifter wrap).
//  - is_weight=0: level = input word verbatim, sat=0, same 3-cycle latency.
//  - sat_count: on each accepted output beat, adds popcount(sat); saturates at 2^CNT_W-1 (no wrap).
//    clr_stats same cycle as increment: clear wins, count = 0.
//  - Lanes independent in arithmetic, shared handshake; mixed is_weight per beat allowed.
// STRUCTURE
//  - Shared package: FP32 field widths/bias (8/23/127), class enum {ZERO, NORM, INF, NAN}, lane stage struct.
//  - Sub-module quantizer_lane: one lane's S1..S3 datapath with enable input; top instantiates four,
//    owns valid pipeline, handshake and sat_count.
// TESTING (LEVEL_W=8, SCALE_EXP=0 unless stated)
//  - RNE: 0x40200000(2.5)->2; 0x40600000(3.5)->4; 0xC0200000(-2.5)->0xFFFFFFFE; 0x3F000000(0.5)->0; sat=0.
//  - Saturation: 0x43480000(200.0)->127 sat=1; 0xC3000000(-128.0)->0xFFFFFF80 sat=0; 0xC3010000(-129.0)->0xFFFFFF80 sat=1;
//    0x7FC00000(NaN)->0 sat=1; 0xFF800000(-Inf)->0xFFFFFF80 sat=1.
//  - Scale/passthrough: SCALE_EXP=2, 0x3E99999A(0.3)->1; is_weight=0 with 0xDEADBEEF -> 0xDEADBEEF, sat=0.
//  - Backpressure: stream 8 beats, out_ready low 5 cycles mid-stream -> in_ready low, outputs stable, all 8 beats in order.
//  - Counter: 2 beats with 3 sat lanes each -> sat_count=6; CNT_W=4 driven to 15 stays 15; clr_stats during increment -> 0.
//  - Reset mid-stream: rst low with 3 beats in flight -> out_valid=0, levels 0, sat_count 0 immediately; clean restart after release.

Source files
------------

// File: rtl/quantizer_pipe_x4_pkg.sv
// Shared FP32 field layout, value classes and per-lane pipeline stage payloads
// for the four-lane FP32 -> signed level quantizer.
package quantizer_pipe_x4_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_BIAS  = 127;
  localparam int unsigned MANT_W   = FP_MAN_W + 1;
  localparam int unsigned E_W      = 10;
  localparam int unsigned AL_W     = 64;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  typedef struct packed {
    logic [FP_W-1:0]          word;
    logic                     is_weight;
    logic                     sign;
    fp_class_e                cls;
    logic [MANT_W-1:0]        mant;
    logic signed [E_W-1:0]    e;
  } lane_s1_t;

  typedef struct packed {
    logic [FP_W-1:0]          word;
    logic                     is_weight;
    logic                     sign;
    fp_class_e                cls;
    logic                     ovf;
    logic [FP_W-1:0]          mag;
    logic                     guard;
    logic                     sticky;
  } lane_s2_t;

  // Denormals are flushed to zero, so exp==0 is always CLS_ZERO.
  function automatic fp_class_e fp_classify(input logic [FP_EXP_W-1:0] exp,
                                            input logic [FP_MAN_W-1:0] frac);
    fp_class_e cls;
    cls = CLS_NORM;
    if (exp == '0)      cls = CLS_ZERO;
    else if (exp == '1) cls = (frac != '0) ? CLS_NAN : CLS_INF;
    return cls;
  endfunction

endpackage

// File: rtl/quantizer_lane.sv
// One lane of the quantizer: S1 classify/exponent, S2 align with guard+sticky,
// S3 round-to-nearest-even, sign and saturate. All stages advance on en.
module quantizer_lane
  import quantizer_pipe_x4_pkg::*;
#(
  parameter int LEVEL_W   = 8,
  parameter int SCALE_EXP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [FP_W-1:0] word_in,
  input  logic            is_weight,
  output logic [FP_W-1:0] level,
  output logic            sat
);

  localparam logic signed [E_W-1:0] SCALE_E = E_W'(SCALE_EXP);
  localparam logic signed [E_W-1:0] BIAS_E  = E_W'(FP_BIAS);
  localparam logic signed [E_W-1:0] OVF_E   = E_W'(LEVEL_W);
  localparam logic signed [E_W-1:0] MIN_E   = E_W'(-1);
  localparam logic [FP_W-1:0] MAX_MAG = FP_W'((64'd1 << (LEVEL_W - 1)) - 64'd1);
  localparam logic [FP_W-1:0] MIN_MAG = FP_W'(64'd1 << (LEVEL_W - 1));
  localparam logic [FP_W-1:0] MIN_LVL = FP_W'(~MIN_MAG + FP_W'(1));

  lane_s1_t        s1_d, s1_q;
  lane_s2_t        s2_d, s2_q;
  logic [AL_W-1:0] base_c, aligned_c;
  logic [FP_W-1:0] rmag_c, level_d;
  logic            inc_c, sat_d;

  always_comb begin
    s1_d.word      = word_in;
    s1_d.is_weight = is_weight;
    s1_d.sign      = word_in[FP_W-1];
    s1_d.cls       = fp_classify(word_in[FP_W-2 -: FP_EXP_W], word_in[FP_MAN_W-1:0]);
    s1_d.mant      = {1'b1, word_in[FP_MAN_W-1:0]};
    s1_d.e         = $signed({2'b00, word_in[FP_W-2 -: FP_EXP_W]}) - BIAS_E + SCALE_E;
  end

  // Fixed point with the binary point between bits 32 and 31; 1.m sits at bit 32 for E=0.
  always_comb begin
    base_c    = {31'd0, s1_q.mant, 9'd0};
    aligned_c = '0;
    if (s1_q.e >= OVF_E || s1_q.e < MIN_E) aligned_c = '0;
    else if (s1_q.e[E_W-1])                 aligned_c = base_c >> 1;
    else                                    aligned_c = base_c << s1_q.e[4:0];
    s2_d.word      = s1_q.word;
    s2_d.is_weight = s1_q.is_weight;
    s2_d.sign      = s1_q.sign;
    s2_d.cls       = s1_q.cls;
    s2_d.ovf       = (s1_q.e >= OVF_E);
    s2_d.mag       = aligned_c[AL_W-1:FP_W];
    s2_d.guard     = aligned_c[FP_W-1];
    s2_d.sticky    = |aligned_c[FP_W-2:0];
  end

  always_comb begin
    inc_c   = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
    rmag_c  = s2_q.mag + FP_W'(inc_c);
    level_d = '0;
    sat_d   = 1'b0;
    if (!s2_q.is_weight) begin
      level_d = s2_q.word;
    end else begin
      case (s2_q.cls)
        CLS_ZERO: level_d = '0;
        CLS_NAN:  sat_d   = 1'b1;
        CLS_INF: begin
          sat_d   = 1'b1;
          level_d = s2_q.sign ? MIN_LVL : MAX_MAG;
        end
        default: begin
          if (s2_q.ovf) begin
            sat_d   = 1'b1;
            level_d = s2_q.sign ? MIN_LVL : MAX_MAG;
          end else if (!s2_q.sign) begin
            sat_d   = (rmag_c > MAX_MAG);
            level_d = sat_d ? MAX_MAG : rmag_c;
          end else begin
            sat_d   = (rmag_c > MIN_MAG);
            level_d = sat_d ? MIN_LVL : FP_W'(FP_W'(0) - rmag_c);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      level <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      level <= level_d;
      sat   <= sat_d;
    end
  end

endmodule

// File: rtl/quantizer_pipe_x4.sv
// Four-lane pipelined FP32 -> signed level quantizer with valid/ready handshake
// and a saturating count of flagged lanes in delivered beats.
module quantizer_pipe_x4
  import quantizer_pipe_x4_pkg::*;
#(
  parameter int          LEVEL_W   = 8,
  parameter int          SCALE_EXP = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  weight_fp1,
  input  logic [FP_W-1:0]  weight_fp2,
  input  logic [FP_W-1:0]  weight_fp3,
  input  logic [FP_W-1:0]  weight_fp4,
  input  logic             is_weight1,
  input  logic             is_weight2,
  input  logic             is_weight3,
  input  logic             is_weight4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  level1,
  output logic [FP_W-1:0]  level2,
  output logic [FP_W-1:0]  level3,
  output logic [FP_W-1:0]  level4,
  output logic [3:0]       sat,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sat_count
);

  localparam int unsigned    SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            en_c, v1_q, v2_q;
  logic [FP_W-1:0] word_a [4];
  logic            isw_a  [4];
  logic [FP_W-1:0] lvl_a  [4];
  logic            sat_a  [4];
  logic [2:0]      pop_c;
  logic [SUM_W-1:0] sum_c;

  assign en_c     = ~out_valid | out_ready;
  assign in_ready = en_c;

  assign word_a[0] = weight_fp1;
  assign word_a[1] = weight_fp2;
  assign word_a[2] = weight_fp3;
  assign word_a[3] = weight_fp4;
  assign isw_a[0]  = is_weight1;
  assign isw_a[1]  = is_weight2;
  assign isw_a[2]  = is_weight3;
  assign isw_a[3]  = is_weight4;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    quantizer_lane #(.LEVEL_W(LEVEL_W), .SCALE_EXP(SCALE_EXP)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en_c),
      .word_in   (word_a[i]),
      .is_weight (isw_a[i]),
      .level     (lvl_a[i]),
      .sat       (sat_a[i])
    );
  end

  assign level1 = lvl_a[0];
  assign level2 = lvl_a[1];
  assign level3 = lvl_a[2];
  assign level4 = lvl_a[3];
  assign sat    = {sat_a[3], sat_a[2], sat_a[1], sat_a[0]};

  // Valid pipeline mirrors the three lane stages; bubbles travel with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
    end else if (en_c) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
    end
  end

  always_comb begin
    pop_c = 3'(sat[0]) + 3'(sat[1]) + 3'(sat[2]) + 3'(sat[3]);
    sum_c = {1'b0, sat_count} + SUM_W'(pop_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         sat_count <= '0;
    else if (clr_stats)               sat_count <= '0;
    else if (out_valid && out_ready)  sat_count <= (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_c[CNT_W-1:0];
  end

endmodule

// File: tb/tb_quantizer_pipe_x4.sv
// Bench: two instances (scale 0 / 16-bit count, scale 2 / 4-bit count) share stimulus;
// a real-arithmetic reference model scores every delivered beat and the saturation count.
module tb_quantizer_pipe_x4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, clr_stats;
  logic [31:0] w [4];
  logic        isw [4];
  logic        ir0, ir1, ov0, ov1;
  logic [31:0] lv0 [4];
  logic [31:0] lv1 [4];
  logic [3:0]  st0, st1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_w [64][4];
  logic        mem_i [64][4];
  int wr = 0;
  int rd [2];
  int mcnt [2];

  quantizer_pipe_x4 #(.LEVEL_W(8), .SCALE_EXP(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .weight_fp1(w[0]), .weight_fp2(w[1]), .weight_fp3(w[2]), .weight_fp4(w[3]),
    .is_weight1(isw[0]), .is_weight2(isw[1]), .is_weight3(isw[2]), .is_weight4(isw[3]),
    .out_valid(ov0), .out_ready(out_ready),
    .level1(lv0[0]), .level2(lv0[1]), .level3(lv0[2]), .level4(lv0[3]),
    .sat(st0), .clr_stats(clr_stats), .sat_count(cnt0));

  quantizer_pipe_x4 #(.LEVEL_W(8), .SCALE_EXP(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .weight_fp1(w[0]), .weight_fp2(w[1]), .weight_fp3(w[2]), .weight_fp4(w[3]),
    .is_weight1(isw[0]), .is_weight2(isw[1]), .is_weight3(isw[2]), .is_weight4(isw[3]),
    .out_valid(ov1), .out_ready(out_ready),
    .level1(lv1[0]), .level2(lv1[1]), .level3(lv1[2]), .level4(lv1[3]),
    .sat(st1), .clr_stats(clr_stats), .sat_count(cnt1));

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: exact real value w*2^scale, round half to even, clamp to [-128,127].
  function automatic logic [32:0] model(input logic [31:0] x, input logic iw, input int scale);
    int  e;
    real mag, fl, fr;
    if (!iw) return {1'b0, x};
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) return {1'b1, 32'd0};
      return x[31] ? {1'b1, 32'hFFFFFF80} : {1'b1, 32'd127};
    end
    if (x[30:23] == 8'h00) return 33'd0;
    e   = int'({24'd0, x[30:23]}) - 127 + scale;
    mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** e);
    fl  = $floor(mag);
    fr  = mag - fl;
    if (fr > 0.5 || (fr == 0.5 && (fl / 2.0) != $floor(fl / 2.0))) fl = fl + 1.0;
    if (!x[31]) begin
      if (fl > 127.0) return {1'b1, 32'd127};
      return {1'b0, 32'($rtoi(fl))};
    end
    if (fl > 128.0) return {1'b1, 32'hFFFFFF80};
    return {1'b0, 32'(-$rtoi(fl))};
  endfunction

  function automatic logic [131:0] exp_beat(input int idx, input int scale);
    logic [131:0] r;
    logic [32:0]  m;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      m = model(mem_w[idx][k], mem_i[idx][k], scale);
      r[32*k +: 32] = m[31:0];
      r[128 + k]    = m[32];
    end
    return r;
  endfunction

  logic         m_o, m_r;
  logic [15:0]  m_c;
  logic [131:0] m_act, m_exp;
  int           m_sc, m_max, m_nxt;

  // Compare process: handshake, beat contents/order/stability and sat_count every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      rd[0] = wr; rd[1] = wr; mcnt[0] = 0; mcnt[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_o   = (d == 0) ? ov0 : ov1;
        m_r   = (d == 0) ? ir0 : ir1;
        m_c   = (d == 0) ? cnt0 : {12'd0, cnt1};
        m_act = (d == 0) ? {st0, lv0[3], lv0[2], lv0[1], lv0[0]}
                         : {st1, lv1[3], lv1[2], lv1[1], lv1[0]};
        m_sc  = (d == 0) ? 0 : 2;
        m_max = (d == 0) ? 65535 : 15;
        check($sformatf("in_ready_d%0d", d), 132'(m_r), 132'(!m_o | out_ready));
        check($sformatf("sat_count_d%0d", d), 132'(m_c), 132'(mcnt[d]));
        m_nxt = mcnt[d];
        if (m_o) begin
          if (rd[d] == wr) begin
            tests++; fails++;
            $display("FAIL extra_beat_d%0d: got %h want no beat", d, m_act);
          end else begin
            m_exp = exp_beat(rd[d], m_sc);
            check($sformatf("beat%0d_d%0d", rd[d], d), m_act, m_exp);
            if (out_ready) begin
              m_nxt = mcnt[d] + $countones(m_exp[131:128]);
              if (m_nxt > m_max) m_nxt = m_max;
              rd[d]++;
            end
          end
        end
        if (clr_stats) m_nxt = 0;
        mcnt[d] = m_nxt;
      end
      if (in_valid && ir0) begin
        for (int k = 0; k < 4; k++) begin
          mem_w[wr][k] = w[k];
          mem_i[wr][k] = isw[k];
        end
        wr++;
      end
    end
  end

  task automatic send4(input logic [31:0] a, b, c, d, input logic [3:0] iw);
    logic ok;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int k = 0; k < 4; k++) isw[k] = iw[k];
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = ir0;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready low for 50 cycles want accept");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && !(rd[0] == wr && rd[1] == wr); n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("drained_d0", 132'(rd[0]), 132'(wr));
    check("drained_d1", 132'(rd[1]), 132'(wr));
  endtask

  int lat;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    for (int k = 0; k < 4; k++) begin w[k] = '0; isw[k] = 1'b1; end
    rd[0] = 0; rd[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
    #12;
    check("rst_out_valid", 132'({ov0, ov1}), 132'(0));
    check("rst_levels", 132'({lv0[0], lv0[3], lv1[1]}), 132'(0));
    check("rst_sat_cnt", 132'({st0, st1, cnt0, cnt1}), 132'(0));

    check("pin_2p5",   132'(model(32'h40200000, 1'b1, 0)), 132'({1'b0, 32'd2}));
    check("pin_3p5",   132'(model(32'h40600000, 1'b1, 0)), 132'({1'b0, 32'd4}));
    check("pin_m2p5",  132'(model(32'hC0200000, 1'b1, 0)), 132'({1'b0, 32'hFFFFFFFE}));
    check("pin_0p5",   132'(model(32'h3F000000, 1'b1, 0)), 132'({1'b0, 32'd0}));
    check("pin_200",   132'(model(32'h43480000, 1'b1, 0)), 132'({1'b1, 32'd127}));
    check("pin_m128",  132'(model(32'hC3000000, 1'b1, 0)), 132'({1'b0, 32'hFFFFFF80}));
    check("pin_m129",  132'(model(32'hC3010000, 1'b1, 0)), 132'({1'b1, 32'hFFFFFF80}));
    check("pin_nan",   132'(model(32'h7FC00000, 1'b1, 0)), 132'({1'b1, 32'd0}));
    check("pin_minf",  132'(model(32'hFF800000, 1'b1, 0)), 132'({1'b1, 32'hFFFFFF80}));
    check("pin_scale", 132'(model(32'h3E99999A, 1'b1, 2)), 132'({1'b0, 32'd1}));
    check("pin_pass",  132'(model(32'hDEADBEEF, 1'b0, 0)), 132'({1'b0, 32'hDEADBEEF}));

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed spec vectors; first beat also measures latency.
    send4(32'h40200000, 32'h40600000, 32'hC0200000, 32'h3F000000, 4'b1111);
    lat = 1;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 132'(lat), 132'(3));
    send4(32'h43480000, 32'hC3000000, 32'hC3010000, 32'h7FC00000, 4'b1111);
    send4(32'hFF800000, 32'h3E99999A, 32'hDEADBEEF, 32'h80000000, 4'b1011);
    send4(32'h7F800000, 32'h00400000, 32'h3FC00000, 32'hBF400000, 4'b1111);
    send4(32'h4F000000, 32'hC2FF0000, 32'h42FF0000, 32'h3F400000, 4'b1111);
    drain();

    // Backpressure: 8-beat stream with out_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send4(32'h3F800000 + 32'(i) * 32'h00100000,
                32'h3F800000 + 32'(i) * 32'h00100000 + 32'h00800000,
                32'hBF800000 + 32'(i) * 32'h00100000 + 32'h01000000,
                32'h3F800000 + 32'(i) * 32'h00100000 + 32'h01800000,
                (i == 5) ? 4'b1011 : 4'b1111);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("stall_in_ready", 132'(ir0), 132'(0));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Saturation counter.
    clr_stats = 1'b1; @(posedge clk); #1 clr_stats = 1'b0;
    check("clr_idle", 132'({cnt0, cnt1}), 132'(0));
    repeat (2) send4(32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h3F800000, 4'b1111);
    drain();
    check("cnt6_d0", 132'(cnt0), 132'(6));
    check("cnt6_d1", 132'(cnt1), 132'(6));
    repeat (3) send4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 4'b1111);
    drain();
    check("cnt18_d0", 132'(cnt0), 132'(18));
    check("cnt_sat_d1", 132'(cnt1), 132'(15));
    send4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 4'b1111);
    drain();
    check("cnt22_d0", 132'(cnt0), 132'(22));
    check("cnt_hold_d1", 132'(cnt1), 132'(15));

    // Reset with three beats in flight.
    out_ready = 1'b0;
    send4(32'h40200000, 32'h43480000, 32'hC0200000, 32'h3F800000, 4'b1111);
    send4(32'h40600000, 32'h3F800000, 32'h40000000, 32'h7FC00000, 4'b1111);
    send4(32'hC3000000, 32'h40400000, 32'h40800000, 32'h3FC00000, 4'b1111);
    check("pre_rst_valid", 132'(ov0), 132'(1));
    #3 rst = 1'b0;
    #1;
    check("mid_rst_valid", 132'({ov0, ov1}), 132'(0));
    check("mid_rst_levels", 132'({lv0[0], lv0[1], lv1[0]}), 132'(0));
    check("mid_rst_cnt", 132'({st0, cnt0, cnt1}), 132'(0));
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 132'(ov0), 132'(0));
    send4(32'h40200000, 32'hDEADBEEF, 32'hC3010000, 32'h3F000000, 4'b1101);
    send4(32'h40600000, 32'hFF800000, 32'h3E99999A, 32'h00000000, 4'b1111);
    drain();

    // Clear coincident with an increment: clear wins.
    send4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 4'b1111);
    for (int n = 0; n < 20 && !ov0; n++) begin @(posedge clk); #1; end
    check("clr_align_valid", 132'(ov0), 132'(1));
    clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    check("clr_wins_d0", 132'(cnt0), 132'(0));
    check("clr_wins_d1", 132'(cnt1), 132'(0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
